ks_ram_responder: RTL and testbench

KS_RAM_RESPONDER -- requirements
Module: ks_ram_responder

---
 rtl/ks_ram_if.sv | 33 +++
 rtl/ks_ram_responder.sv | 122 ++++++++++++
 tb/tb_ks_ram_responder.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ks_ram_if.sv
// Core/loader bus of the KS RAM responder.
// Handshakes:
//   core port : the core raises ram_req together with ram_write_enable,
//               ram_addr and data_in, and keeps ram_req high until it sees
//               ram_ready. The responder samples the request on the clock edge
//               that accepts it. ram_ready is a one-cycle completion pulse.
//               data_out is valid from that pulse until the next read completes.
//   load port : a word transfers on any edge where load_valid && load_ready.
//               If load_ready is low, nothing is written and the loader retries.
interface ks_ram_if;
  logic        ram_req;
  logic        ram_write_enable;
  logic [4:0]  ram_addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        ram_ready;
  logic        load_valid;
  logic [4:0]  load_addr;
  logic [15:0] load_data;
  logic        load_ready;

  modport master (
    output ram_req, ram_write_enable, ram_addr, data_in,
    output load_valid, load_addr, load_data,
    input  data_out, ram_ready, load_ready
  );

  modport slave (
    input  ram_req, ram_write_enable, ram_addr, data_in,
    input  load_valid, load_addr, load_data,
    output data_out, ram_ready, load_ready
  );
endinterface

// File: rtl/ks_ram_responder.sv
// Wait-stated 32 x 16 RAM serving a small core. A program loader can also
// write to it, but only while the core is idle.
module ks_ram_responder #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  ks_ram_if.slave    bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        enter_done;
  logic        we_q;
  logic [4:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] dout_q;
  logic        acc_we;
  logic [4:0]  acc_addr;
  logic [15:0] acc_data;

  logic [15:0] mem [DEPTH];

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count down the wait states, and pulse DONE once.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ram_req) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WS_LOAD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request at acceptance so later bus changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 16'h0000;
    end else if (accept) begin
      we_q    <= bus.ram_write_enable;
      addr_q  <= bus.ram_addr;
      wdata_q <= bus.data_in;
    end
  end

  // With zero wait states DONE is entered on the acceptance edge itself,
  // so the access has to use the live bus values rather than the captured copy.
  always_comb begin
    acc_we   = (state == IDLE) ? bus.ram_write_enable : we_q;
    acc_addr = (state == IDLE) ? bus.ram_addr         : addr_q;
    acc_data = (state == IDLE) ? bus.data_in          : wdata_q;
  end

  assign enter_done = (state_nxt == DONE);

  // Read data register: updated only when a read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 16'h0000;
    end else if (enter_done && !acc_we) begin
      dout_q <= mem[acc_addr];
    end
  end

  // Memory array: never cleared. Writes are blocked while reset is held, so an
  // access that reset aborts leaves the array untouched. A core write and a
  // load cannot coincide, because a load needs IDLE with no request pending.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (enter_done && acc_we) begin
        mem[acc_addr] <= acc_data;
      end else if (bus.load_valid && bus.load_ready) begin
        mem[bus.load_addr] <= bus.load_data;
      end
    end
  end

  assign bus.load_ready = (state == IDLE) && !bus.ram_req;
  assign bus.ram_ready  = (state == DONE);
  assign bus.data_out   = dout_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_ks_ram_responder.sv
// Testbench for ks_ram_responder. It drives one instance with two wait
// states and one with zero wait states. The reference model is a plain word
// array plus the last read value; expected read data goes through exp_q.
module tb_ks_ram_responder;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_a, dbg_b;

  ks_ram_if bus_a();
  ks_ram_if bus_b();

  ks_ram_responder #(.WAIT_STATES(WS), .DEPTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .dbg_state(dbg_a)
  );

  ks_ram_responder #(.WAIT_STATES(0), .DEPTH(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .dbg_state(dbg_b)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] mem_m [32];
  logic [15:0] dout_m;
  logic [15:0] exp_q [$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic init_inputs();
    bus_a.ram_req = 0; bus_a.ram_write_enable = 0; bus_a.ram_addr = 0; bus_a.data_in = 0;
    bus_a.load_valid = 0; bus_a.load_addr = 0; bus_a.load_data = 0;
    bus_b.ram_req = 0; bus_b.ram_write_enable = 0; bus_b.ram_addr = 0; bus_b.data_in = 0;
    bus_b.load_valid = 0; bus_b.load_addr = 0; bus_b.load_data = 0;
  endtask

  // Driver: one program-load word through the load port of the main DUT.
  task automatic load_word(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_a.ram_req = 0;
    bus_a.load_valid = 1; bus_a.load_addr = a; bus_a.load_data = d;
    #1;
    tests_run++;
    if (bus_a.load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_ready_idle addr=%0d got=%b want=1", a, bus_a.load_ready);
    end
    @(negedge clk);
    bus_a.load_valid = 0;
    mem_m[a] = d;
  endtask

  task automatic start_access(input logic we, input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_a.ram_req = 1; bus_a.ram_write_enable = we; bus_a.ram_addr = a; bus_a.data_in = d;
  endtask

  // Wait for completion; optionally scramble the bus and attempt loads while the access is in flight.
  task automatic wait_done(input logic we, input logic [4:0] a, input logic [15:0] d,
                           input bit scramble, input logic [4:0] alt_addr);
    int n = 0;
    bit got = 0;
    logic [15:0] exp;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus_a.ram_ready === 1'b1) begin
        got = 1;
      end else begin
        tests_run++;
        if (bus_a.data_out !== dout_m) begin
          tests_failed++;
          $display("FAIL dout_hold cycle=%0d got=%h want=%h", n, bus_a.data_out, dout_m);
        end
        if (scramble) begin
          bus_a.ram_addr = alt_addr;
          bus_a.data_in = 16'($urandom);
          bus_a.ram_write_enable = 1'($urandom);
          bus_a.load_valid = 1'($urandom);
          bus_a.load_addr = 5'($urandom);
          bus_a.load_data = 16'($urandom);
        end
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL ready_timeout addr=%0d got=no ready want=ready within %0d", a, WS + 1);
    end else if (n != WS + 1) begin
      tests_failed++;
      $display("FAIL latency addr=%0d got=%0d want=%0d", a, n, WS + 1);
    end
    if (got) begin
      if (!we) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (bus_a.data_out !== exp) begin
          tests_failed++;
          $display("FAIL read_data addr=%0d got=%h want=%h", a, bus_a.data_out, exp);
        end
        dout_m = exp;
      end else begin
        tests_run++;
        if (bus_a.data_out !== dout_m) begin
          tests_failed++;
          $display("FAIL write_keeps_dout addr=%0d got=%h want=%h", a, bus_a.data_out, dout_m);
        end
        mem_m[a] = d;
      end
    end
    bus_a.ram_req = 0;
    bus_a.load_valid = 0;
    @(negedge clk);
    tests_run++;
    if (bus_a.ram_ready !== 1'b0 || dbg_a !== 2'd0) begin
      tests_failed++;
      $display("FAIL ready_one_cycle got ready=%b state=%0d want ready=0 state=0", bus_a.ram_ready, dbg_a);
    end
  endtask

  task automatic core_access(input logic we, input logic [4:0] a, input logic [15:0] d,
                             input bit scramble, input logic [4:0] alt_addr);
    if (!we) exp_q.push_back(mem_m[a]);
    start_access(we, a, d);
    wait_done(we, a, d, scramble, alt_addr);
  endtask

  task automatic test_reset();
    init_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (dbg_a !== 2'd0 || bus_a.ram_ready !== 1'b0 || bus_a.data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_state got state=%0d ready=%b dout=%h want 0/0/0000", dbg_a, bus_a.ram_ready, bus_a.data_out);
    end
    tests_run++;
    if (bus_a.load_ready !== 1'b1 || bus_b.data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_load_ready got load_ready=%b dout0=%h want 1/0000", bus_a.load_ready, bus_b.data_out);
    end
    rst_n = 1;
    dout_m = 16'h0000;
    for (int i = 0; i < 32; i++) load_word(5'(i), 16'($urandom));
  endtask

  task automatic test_load_read();
    load_word(5'd3, 16'h8125);
    core_access(1'b0, 5'd3, 16'h0, 1'b0, 5'd0);
    tests_run++;
    if (bus_a.data_out !== 16'h8125) begin
      tests_failed++;
      $display("FAIL load_then_read got=%h want=8125", bus_a.data_out);
    end
  endtask

  task automatic test_write_read();
    core_access(1'b1, 5'd31, 16'hBEEF, 1'b0, 5'd0);
    tests_run++;
    if (bus_a.data_out !== 16'h8125) begin
      tests_failed++;
      $display("FAIL write_no_dout_change got=%h want=8125", bus_a.data_out);
    end
    core_access(1'b0, 5'd31, 16'h0, 1'b0, 5'd0);
    tests_run++;
    if (bus_a.data_out !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL write_then_read got=%h want=beef", bus_a.data_out);
    end
  endtask

  task automatic test_arbitration();
    load_word(5'd5, 16'h5555);
    start_access(1'b1, 5'd10, 16'h0A0A);
    bus_a.load_valid = 1; bus_a.load_addr = 5'd5; bus_a.load_data = 16'h1234;
    #1;
    tests_run++;
    if (bus_a.load_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL arb_load_ready got=%b want=0", bus_a.load_ready);
    end
    @(posedge clk);
    #1 bus_a.load_valid = 0;
    wait_done(1'b1, 5'd10, 16'h0A0A, 1'b0, 5'd0);
    core_access(1'b0, 5'd5, 16'h0, 1'b0, 5'd0);
    tests_run++;
    if (bus_a.data_out !== 16'h5555) begin
      tests_failed++;
      $display("FAIL arb_load_dropped got=%h want=5555", bus_a.data_out);
    end
  endtask

  task automatic test_reset_abort();
    bit seen_ready = 0;
    load_word(5'd7, 16'h0707);
    start_access(1'b1, 5'd7, 16'hAAAA);
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    bus_a.ram_req = 0;
    #1;
    tests_run++;
    if (dbg_a !== 2'd0 || bus_a.ram_ready !== 1'b0 || bus_a.data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL abort_reset_state got state=%0d ready=%b dout=%h want 0/0/0000", dbg_a, bus_a.ram_ready, bus_a.data_out);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus_a.ram_ready === 1'b1) seen_ready = 1;
    end
    tests_run++;
    if (seen_ready) begin
      tests_failed++;
      $display("FAIL abort_no_ready got=ready pulse want=none");
    end
    rst_n = 1;
    dout_m = 16'h0000;
    core_access(1'b0, 5'd7, 16'h0, 1'b0, 5'd0);
    tests_run++;
    if (bus_a.data_out !== 16'h0707) begin
      tests_failed++;
      $display("FAIL abort_mem_unchanged got=%h want=0707", bus_a.data_out);
    end
  endtask

  task automatic test_scramble();
    logic [15:0] d2, d9;
    d2 = 16'($urandom);
    d9 = ~d2;
    load_word(5'd2, d2);
    load_word(5'd9, d9);
    core_access(1'b0, 5'd2, 16'h0, 1'b1, 5'd9);
    tests_run++;
    if (bus_a.data_out !== d2) begin
      tests_failed++;
      $display("FAIL addr_change_in_wait got=%h want=%h", bus_a.data_out, d2);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r0, r1;
    r0 = 16'($urandom);
    r1 = ~r0;
    @(negedge clk);
    bus_b.load_valid = 1; bus_b.load_addr = 5'd0; bus_b.load_data = r0;
    @(negedge clk);
    bus_b.load_addr = 5'd1; bus_b.load_data = r1;
    @(negedge clk);
    bus_b.load_valid = 0;
    bus_b.ram_req = 1; bus_b.ram_write_enable = 0; bus_b.ram_addr = 5'd0;
    @(negedge clk);
    tests_run++;
    if (bus_b.ram_ready !== 1'b1 || bus_b.data_out !== r0) begin
      tests_failed++;
      $display("FAIL zw_first got ready=%b dout=%h want 1/%h", bus_b.ram_ready, bus_b.data_out, r0);
    end
    bus_b.ram_addr = 5'd1;
    @(negedge clk);
    tests_run++;
    if (bus_b.ram_ready !== 1'b0 || dbg_b !== 2'd0 || bus_b.data_out !== r0) begin
      tests_failed++;
      $display("FAIL zw_idle_gap got ready=%b state=%0d dout=%h want 0/0/%h", bus_b.ram_ready, dbg_b, bus_b.data_out, r0);
    end
    @(negedge clk);
    tests_run++;
    if (bus_b.ram_ready !== 1'b1 || bus_b.data_out !== r1) begin
      tests_failed++;
      $display("FAIL zw_second got ready=%b dout=%h want 1/%h", bus_b.ram_ready, bus_b.data_out, r1);
    end
    bus_b.ram_req = 0;
    @(negedge clk);
    tests_run++;
    if (bus_b.ram_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL zw_end got ready=%b want 0", bus_b.ram_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 3);
      if (k == 0) load_word(5'($urandom), 16'($urandom));
      else core_access(1'($urandom), 5'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 5'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL exp_q_drained got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_write_read();
    test_arbitration();
    test_reset_abort();
    test_scramble();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
